// File: rtl/mod_n_cntr.sv
// mod_n_cntr: modulo-N up/down counter with synchronous clear and load,
// an optional saturating mode, and a combinational terminal-count output
// for cascading. When a wrap or an out-of-range load happens, a one-cycle
// registered pulse is raised on wrap or ld_err.
module mod_n_cntr #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 12,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             cnt_en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] count,
  output logic             y,
  output logic             wrap,
  output logic             ld_err
);

  // An illegal modulus cannot be handled at run time, so elaboration stops.
  generate
    if ((MODULUS < 32'sd2) || (MODULUS > (32'sd2 ** WIDTH))) begin : g_bad_modulus
      $error("mod_n_cntr: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
    end
  endgenerate

  // The highest legal count. When MODULUS == 2**WIDTH this value is all
  // ones, so stepping up from it overflows to zero in the usual binary way.
  localparam logic [WIDTH-1:0] TERM_UP  = WIDTH'(MODULUS - 32'sd1);
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  // The modulus is widened by one bit so that MODULUS == 2**WIDTH can
  // still be represented in the load range compare.
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ld_err_q, ld_err_d;
  logic             at_term_s;

  // Detect that the count sits at the terminal value for the current direction.
  always_comb begin
    at_term_s = 1'b0;
    if (up_dn) begin
      at_term_s = (count_q == TERM_UP);
    end else begin
      at_term_s = (count_q == ZERO);
    end
  end

  // Work out the next count and pulses. Priority is clear, then load, then count, then hold.
  always_comb begin
    count_d  = count_q;
    wrap_d   = 1'b0;
    ld_err_d = 1'b0;
    if (clr) begin
      count_d = ZERO;
    end else if (ld) begin
      if ({1'b0, ld_val} < MOD_EXT) begin
        count_d = ld_val;
      end else begin
        count_d  = TERM_UP;
        ld_err_d = 1'b1;
      end
    end else if (cnt_en) begin
      if (at_term_s) begin
        if (SATURATE) begin
          count_d = count_q;
        end else begin
          count_d = up_dn ? ZERO : TERM_UP;
          wrap_d  = 1'b1;
        end
      end else begin
        count_d = up_dn ? (count_q + ONE) : (count_q - ONE);
      end
    end else begin
      count_d = count_q;
    end
  end

  // State register. Reset is asynchronous, so it clears without waiting for a clock edge.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      count_q  <= ZERO;
      wrap_q   <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wrap_q   <= wrap_d;
      ld_err_q <= ld_err_d;
    end
  end

  // y carries out combinationally so counters can be cascaded with no extra cycle of delay.
  always_comb begin
    y = cnt_en & at_term_s;
  end

  assign count  = count_q;
  assign wrap   = wrap_q;
  assign ld_err = ld_err_q;

endmodule

// File: tb/tb_mod_n_cntr.sv
// Testbench for mod_n_cntr. Three instances share one set of inputs:
// a wrapping counter with modulus 12, a saturating counter with modulus 12,
// and a wrapping counter with a full-range modulus of 16. Each instance is
// compared with an arithmetic reference model.
module tb_mod_n_cntr;

  localparam int NDUT = 3;
  localparam int MODS [NDUT] = '{12, 12, 16};
  localparam int SATS [NDUT] = '{0, 1, 0};

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       cnt_en = 1'b0;
  logic       up_dn = 1'b1;
  logic       clr = 1'b0;
  logic       ld = 1'b0;
  logic [3:0] ld_val = 4'd0;

  logic [3:0] cnt_s  [NDUT];
  logic       y_s    [NDUT];
  logic       wrap_s [NDUT];
  logic       err_s  [NDUT];

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_cnt  [NDUT];
  int m_wrap [NDUT];
  int m_err  [NDUT];

  always #5 clk = ~clk;

  mod_n_cntr #(.WIDTH(4), .MODULUS(12), .SATURATE(1'b0)) dut0 (
    .clk(clk), .rstb(rstb), .cnt_en(cnt_en), .up_dn(up_dn), .clr(clr), .ld(ld),
    .ld_val(ld_val), .count(cnt_s[0]), .y(y_s[0]), .wrap(wrap_s[0]), .ld_err(err_s[0]));
  mod_n_cntr #(.WIDTH(4), .MODULUS(12), .SATURATE(1'b1)) dut1 (
    .clk(clk), .rstb(rstb), .cnt_en(cnt_en), .up_dn(up_dn), .clr(clr), .ld(ld),
    .ld_val(ld_val), .count(cnt_s[1]), .y(y_s[1]), .wrap(wrap_s[1]), .ld_err(err_s[1]));
  mod_n_cntr #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) dut2 (
    .clk(clk), .rstb(rstb), .cnt_en(cnt_en), .up_dn(up_dn), .clr(clr), .ld(ld),
    .ld_val(ld_val), .count(cnt_s[2]), .y(y_s[2]), .wrap(wrap_s[2]), .ld_err(err_s[2]));

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, idx, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      m_cnt[i] = 0; m_wrap[i] = 0; m_err[i] = 0;
    end
  endtask

  function automatic int model_y(input int i);
    int term;
    term = up_dn ? (MODS[i] - 1) : 0;
    return (cnt_en && (m_cnt[i] == term)) ? 1 : 0;
  endfunction

  // Apply the counter rules to the model, using the inputs present at the edge.
  task automatic model_edge();
    for (int i = 0; i < NDUT; i++) begin
      int m, c, term;
      m = MODS[i]; c = m_cnt[i];
      term = up_dn ? (m - 1) : 0;
      m_wrap[i] = 0; m_err[i] = 0;
      if (clr) begin
        m_cnt[i] = 0;
      end else if (ld) begin
        if (int'(ld_val) < m) m_cnt[i] = int'(ld_val);
        else begin m_cnt[i] = m - 1; m_err[i] = 1; end
      end else if (cnt_en) begin
        if (SATS[i] != 0 && c == term) m_cnt[i] = c;
        else begin
          m_cnt[i] = up_dn ? (c + 1) % m : (c + m - 1) % m;
          if (c == term) m_wrap[i] = 1;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < NDUT; i++) begin
      chk({tag, ".count"}, i, 32'(cnt_s[i]), 32'(m_cnt[i]));
      chk({tag, ".wrap"}, i, 32'(wrap_s[i]), 32'(m_wrap[i]));
      chk({tag, ".ld_err"}, i, 32'(err_s[i]), 32'(m_err[i]));
    end
  endtask

  // Inputs are already driven. Check y before the edge, then clock once and check the registered outputs.
  task automatic cycle(input string tag);
    #1;
    for (int i = 0; i < NDUT; i++) chk({tag, ".y"}, i, 32'(y_s[i]), 32'(model_y(i)));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic c, input logic l, input logic [3:0] v, input logic e, input logic u);
    clr = c; ld = l; ld_val = v; cnt_en = e; up_dn = u;
  endtask

  initial begin
    // Reset held across two edges, with sync inputs toggling
    model_reset();
    drive(1'b0, 1'b1, 4'd5, 1'b1, 1'b1);
    @(posedge clk); #1;
    check_outputs("in_reset");
    @(posedge clk); #2;
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    rstb = 1'b1;
    @(posedge clk); #1;
    check_outputs("post_rel");

    // Idle with counting disabled
    for (int k = 0; k < 5; k++) cycle("idle");

    // Count up 12 edges
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int k = 0; k < 12; k++) cycle("up");
    chk("up_wrap_lit", 0, 32'(wrap_s[0]), 32'd1);
    chk("up_cnt_lit", 0, 32'(cnt_s[0]), 32'd0);

    // Count down from 0, then reverse direction at 9
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    cycle("dn_wrap");
    chk("dn_wrap_lit", 0, 32'(cnt_s[0]), 32'd11);
    cycle("dn10");
    cycle("dn9");
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    cycle("reverse");
    chk("reverse_lit", 0, 32'(cnt_s[0]), 32'd10);

    // Loads and priority
    drive(1'b0, 1'b1, 4'd14, 1'b0, 1'b1);
    cycle("ld14");
    chk("ld14_lit", 0, 32'(cnt_s[0]), 32'd11);
    chk("ld14_err_lit", 0, 32'(err_s[0]), 32'd1);
    drive(1'b0, 1'b1, 4'd5, 1'b1, 1'b1);
    cycle("ld5_en");
    chk("ld5_lit", 0, 32'(cnt_s[0]), 32'd5);
    drive(1'b1, 1'b1, 4'd7, 1'b1, 1'b1);
    cycle("clr_ld");
    drive(1'b0, 1'b1, 4'd11, 1'b1, 1'b1);
    cycle("ld11");
    cycle("ld_at_term");
    chk("ld_nowrap_lit", 0, 32'(wrap_s[0]), 32'd0);
    drive(1'b0, 1'b1, 4'd15, 1'b1, 1'b1);
    cycle("ld15");
    drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    cycle("clr_at_term");

    // Saturating climb, and full-range binary overflow on the 16-state counter
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int k = 0; k < 16; k++) cycle("sat_up");
    chk("sat_hold_lit", 1, 32'(cnt_s[1]), 32'd11);
    chk("sat_y_lit", 1, 32'(y_s[1]), 32'd1);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int k = 0; k < 18; k++) cycle("dn_long");

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(15, 0) == 0), ($urandom_range(7, 0) == 0),
            4'($urandom_range(15, 0)), ($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)));
      cycle("rand");
    end

    // Asynchronous reset asserted between edges at count 7
    drive(1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
    cycle("ld7");
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    cycle("to8");
    drive(1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
    cycle("ld7b");
    #2;
    rstb = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    drive(1'b0, 1'b1, 4'd9, 1'b1, 1'b0);
    #1;
    for (int i = 0; i < NDUT; i++) chk("rst_y", i, 32'(y_s[i]), 32'd1);
    @(posedge clk); #1;
    check_outputs("rst_ignore");
    #2;
    rstb = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) cycle("resume");
    chk("resume_lit", 0, 32'(cnt_s[0]), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
